// File: rtl/ads8556_emu.sv
`default_nettype none
// ============================================================================
//  Module   : ads8556_emu
//  Purpose  : Device-side model of one ADS8556 six-channel ADC on its
//             parallel interface. Answers CONVST with BUSY, returns six
//             patterned 16-bit results on successive RD strobes and captures
//             two-word configuration writes.
//  Revision : 1.0  initial release
// ============================================================================
module ads8556_emu #(
   parameter int unsigned BUSY_CYCLES = 150,
   parameter logic [15:0] CH_STEP     = 16'h1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ads8556_conv,
   input  logic        ads8556_csn,
   input  logic        ads8556_rdn,
   input  logic        ads8556_wrn,
   input  logic        ads8556_reset,
   output logic        ads8556_busy,
   input  logic [15:0] ads8556_data_i,
   output logic [15:0] ads8556_data_o,
   output logic        ads8556_data_oe,
   input  logic        pattern_mode,
   input  logic [15:0] const_val,
   output logic [31:0] cfg_reg,
   output logic [15:0] conv_count,
   output logic        conv_miss
);

   localparam logic [15:0] c_busy_last = 16'(BUSY_CYCLES - 1);
   localparam int          c_nch       = 6;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   // synchronizer chains (bit 1 is the synced value)
   logic [1:0]  conv_sync_q, csn_sync_q, rdn_sync_q, wrn_sync_q, rst_sync_q;
   logic [15:0] data_meta_q, data_sync_q;
   // previous synced values for edge detection
   logic        conv_prev_q, csn_prev_q, rdn_prev_q, wrn_prev_q;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] sample_q [c_nch];
   logic [2:0]  ptr_q;
   logic [15:0] count_q;
   logic        miss_q;
   logic        widx_q;
   logic [15:0] hold_q;
   logic [31:0] cfg_q;
   logic        oe_q;
   logic [15:0] dout_q;

   logic        w_conv_s, w_csn_s, w_rdn_s, w_wrn_s, w_dev_rst;
   logic        w_conv_rise, w_rd_rise, w_wr_rise, w_oe_d;
   logic        w_conv_done, w_miss_set;
   logic [15:0] w_pat [c_nch];

   assign w_conv_s  = conv_sync_q[1];
   assign w_csn_s   = csn_sync_q[1];
   assign w_rdn_s   = rdn_sync_q[1];
   assign w_wrn_s   = wrn_sync_q[1];
   assign w_dev_rst = rst_sync_q[1];

   // Chip select is judged by its pre-edge value so that csn and rdn/wrn
   // rising together still count as a strobe.
   assign w_conv_rise = w_conv_s & ~conv_prev_q;
   assign w_rd_rise   = w_rdn_s & ~rdn_prev_q & ~csn_prev_q;
   assign w_wr_rise   = w_wrn_s & ~wrn_prev_q & ~csn_prev_q;
   assign w_oe_d      = ~w_csn_s & ~w_rdn_s;

   // Two-flop synchronizers and edge-detect history for all host pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_sync_q <= 2'b00;
         csn_sync_q  <= 2'b11;
         rdn_sync_q  <= 2'b11;
         wrn_sync_q  <= 2'b11;
         rst_sync_q  <= 2'b00;
         data_meta_q <= '0;
         data_sync_q <= '0;
         conv_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
         rdn_prev_q  <= 1'b1;
         wrn_prev_q  <= 1'b1;
      end else begin
         conv_sync_q <= {conv_sync_q[0], ads8556_conv};
         csn_sync_q  <= {csn_sync_q[0], ads8556_csn};
         rdn_sync_q  <= {rdn_sync_q[0], ads8556_rdn};
         wrn_sync_q  <= {wrn_sync_q[0], ads8556_wrn};
         rst_sync_q  <= {rst_sync_q[0], ads8556_reset};
         data_meta_q <= ads8556_data_i;
         data_sync_q <= data_meta_q;
         conv_prev_q <= w_conv_s;
         csn_prev_q  <= w_csn_s;
         rdn_prev_q  <= w_rdn_s;
         wrn_prev_q  <= w_wrn_s;
      end
   end

   // Conversion FSM state and busy counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: device reset dominates any CONVST edge
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_conv_done = 1'b0;
      w_miss_set  = 1'b0;
      if (w_dev_rst) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_conv_rise) begin
                  state_d = S_CONV;
                  cnt_d   = '0;
               end
            end
            S_CONV: begin
               if (w_conv_rise) w_miss_set = 1'b1;
               if (cnt_q == c_busy_last) begin
                  state_d     = S_IDLE;
                  cnt_d       = '0;
                  w_conv_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Pattern generator: ramp uses the pre-increment conversion count
   always_comb begin
      for (int k = 0; k < c_nch; k++) begin
         w_pat[k] = pattern_mode ? (const_val + 16'(k))
                                 : (count_q + 16'(k) * CH_STEP);
      end
   end

   // Sample bank, read pointer, conversion counter and miss flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < c_nch; k++) sample_q[k] <= '0;
         ptr_q   <= '0;
         count_q <= '0;
         miss_q  <= 1'b0;
      end else begin
         if (w_dev_rst) begin
            for (int k = 0; k < c_nch; k++) sample_q[k] <= '0;
            ptr_q <= '0;
         end else if (w_conv_done) begin
            sample_q <= w_pat;
            ptr_q    <= '0;
         end else if (w_rd_rise) begin
            ptr_q <= (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
         end
         if (w_conv_done) count_q <= count_q + 16'd1;
         if (w_miss_set)  miss_q  <= 1'b1;
      end
   end

   // Two-word configuration capture: high word held, low word commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widx_q <= 1'b0;
         hold_q <= '0;
         cfg_q  <= '0;
      end else if (w_dev_rst) begin
         widx_q <= 1'b0;
         hold_q <= '0;
         cfg_q  <= '0;
      end else if (w_wr_rise) begin
         if (!widx_q) hold_q <= data_sync_q;
         else         cfg_q  <= {hold_q, data_sync_q};
         widx_q <= ~widx_q;
      end
   end

   // Read bus: enable registered from synced strobes, data holds when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_q   <= 1'b0;
         dout_q <= '0;
      end else begin
         oe_q <= w_oe_d;
         if (w_oe_d) dout_q <= sample_q[ptr_q];
      end
   end

   assign ads8556_busy    = (state_q == S_CONV);
   assign ads8556_data_o  = dout_q;
   assign ads8556_data_oe = oe_q;
   assign cfg_reg         = cfg_q;
   assign conv_count      = count_q;
   assign conv_miss       = miss_q;

endmodule
`default_nettype wire

// File: doc/ads8556_emu.md
# ads8556_emu

Synthesizable device-side model of one ADS8556 six-channel ADC on its parallel interface. It answers the host-side ADS8556 controller exactly as the silicon would: it accepts CONVST, drives BUSY and returns six 16-bit results on successive RD strobes. It also captures the two-word configuration writes. It replaces the ADC in loopback/HIL builds so the DAQ and TCD1304 chain can be checked with known data patterns.

## Interface
Parameters:
- BUSY_CYCLES, 150, number of clk cycles BUSY stays high per conversion (1.5 µs at 100 MHz); legal range 2..65535.
- CH_STEP, 16'h1000, per-channel offset added in ramp mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ads8556_conv  in  1  CONVST from host; a rising edge starts a conversion.
- ads8556_csn  in  1  chip select, active low.
- ads8556_rdn  in  1  read strobe, active low.
- ads8556_wrn  in  1  write strobe, active low.
- ads8556_reset  in  1  device reset, active high.
- ads8556_busy  out  1  conversion in progress.
- ads8556_data_i  in  16  bus value driven by host during writes.
- ads8556_data_o  out  16  bus value driven by emulator during reads.
- ads8556_data_oe  out  1  output enable for the top-level tristate buffer.
- pattern_mode  in  1  0 = ramp pattern, 1 = constant pattern.
- const_val  in  16  base value used in constant mode.
- cfg_reg  out  32  last complete configuration written by host.
- conv_count  out  16  number of completed conversions; wraps modulo 2^16.
- conv_miss  out  1  sticky flag: CONVST edge received while busy.

## Operation
- Input synchronizers:
  - conv, csn, rdn, wrn, reset and data_i each pass through 2-FF synchronizers.
  - Synchronizer reset levels: conv 0, csn/rdn/wrn 1, reset 0, data 0.
  - All edge detection compares the synced value with its previous registered value.
- State machine states:
  - IDLE → CONV on a conv rising edge.
  - CONV → IDLE when the busy counter reaches BUSY_CYCLES-1.
  - A conv rising edge seen in CONV is ignored and sets conv_miss.
- At the CONV→IDLE transition:
  - sample[k] (k = 0..5) is latched from the pattern generator.
  - read pointer ptr is cleared to 0.
  - conv_count increments.
- Pattern generator:
  - Ramp (pattern_mode = 0): sample[k] = conv_count + k*CH_STEP, mod 2^16. conv_count is the pre-increment value.
  - Constant (pattern_mode = 1): sample[k] = const_val + k, mod 2^16.
- Read path:
  - ads8556_data_oe = registered (!csn_s & !rdn_s).
  - ads8556_data_o = sample[ptr] whenever oe is high; otherwise it holds its last value.
  - A rdn rising edge while csn_s = 0 advances ptr; ptr wraps 5 → 0.
  - Reads are serviced in either state. During CONV, reads return the previous conversion.
- Write path:
  - A wrn rising edge while csn_s = 0 captures data_i_s.
  - Word index 0 stores into a holding register; word index 1 updates cfg_reg = {hold, data_i_s}.
  - The word index toggles on each write.
- ads8556_reset_s high (level):
  - Effect: state → IDLE, busy → 0, ptr → 0, word index → 0, cfg_reg → 0, samples → 0.
  - conv_count and conv_miss are kept.
  - CONVST is ignored while reset is high.
- rst_n low: every register clears. Output reset values: busy 0, data_o 0, data_oe 0, cfg_reg 0, conv_count 0, conv_miss 0.
- Simultaneous events in one cycle:
  - reset with conv edge: reset wins.
  - rdn edge with conversion end: ptr clears to 0 (conversion end wins).
  - csn rising together with rdn rising: counted as a read edge, because csn_s is sampled in its pre-edge state.

## Timing
- Input pin change at cycle t appears on the synced signal at t+2; the edge is detected at t+2.
- Conv pin rises at t: ads8556_busy goes high at t+3 and stays high exactly BUSY_CYCLES cycles.
- Samples and conv_count update in the same cycle that busy falls.
- csn and rdn both low from cycle t: data_oe and data_o valid at t+3.
- rdn rises at t: ptr advances at t+3; the new data_o is visible at the next oe-high cycle.
- Host strobes must be ≥ 3 clk low and ≥ 3 clk high to be seen reliably.

## Test plan
- Reset release, then conv pulse (4 cycles) → busy high 3 cycles after edge for exactly 150 cycles. Then six RD strobes return 0x0000, 0x1000, 0x2000, 0x3000, 0x4000, 0x5000, and conv_count = 1.
- Second conversion with a 7th strobe → data 0x0001, 0x1001, …, 0x5001, then the 7th read returns 0x0001 (wrap).
- pattern_mode = 1, const_val = 0xFFFE → reads return 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003.
- Two writes 0xA5A5 then 0x3C3C with csn low → cfg_reg = 0xA5A53C3C after the second wrn rise, unchanged after the first. A write with csn high is ignored.
- Conv edge issued 50 cycles into CONV → busy width still 150 cycles, conv_miss = 1 and stays set.
- ads8556_reset pulsed mid-CONV → busy drops within 4 cycles, cfg_reg = 0, ptr = 0, conv_count retained. The next conversion completes normally.
